// File: rtl/obst_lane_sched.sv
// Game scheduler for rotating obstacle rows: shift ticks, collision detection, IDLE/PLAY/WIN/LOSS FSM.
// All outputs registered (1 cycle after inputs); no backpressure. OBST_SCORE_EN adds an 8-bit win score.
module obst_lane_sched #(
    parameter int LANES    = 4,
    parameter int TICK_DIV = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2:0]           player_row,
    input  logic [3:0]           player_col,
    input  logic [16*LANES-1:0]  lane_bits,
    output logic [LANES-1:0]     lane_enable,
    output logic [LANES-1:0]     lane_dir,
    output logic                 win,
    output logic                 loss,
    output logic [1:0]           level,
`ifdef OBST_SCORE_EN
    output logic [7:0]           score,
`endif
    output logic [1:0]           state
);

    localparam int CW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        WIN  = 2'd2,
        LOSS = 2'd3
    } state_t;

    function automatic logic [LANES-1:0] dir_reset_pattern();
        logic [LANES-1:0] p;
        for (int i = 0; i < LANES; i++) p[i] = (i % 2 == 1);
        return p;
    endfunction

    localparam logic [LANES-1:0] DIR_RST = dir_reset_pattern();

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW:0]      period;
    logic             tick, hit, goal;
    logic [LANES-1:0] en_d, dir_d;
    logic [1:0]       level_d;

    assign state = state_q;

    always_comb begin
        period = (CW+1)'(TICK_DIV >> level);
        if (period == '0) period = 1;
    end

    assign tick = (cnt_q == CW'(period - 1'b1));
    assign goal = (player_row == 3'(LANES + 1));

    // Rows outside 1..LANES (start zone, goal, out-of-range) can never collide.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < LANES; i++)
            if (player_row == 3'(i + 1)) hit = lane_bits[16*i + int'(player_col)];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        en_d    = '0;
        level_d = level;
        dir_d   = lane_dir;
        case (state_q)
            IDLE: if (start) begin
                state_d = PLAY;
                cnt_d   = '0;
            end
            PLAY: begin
                cnt_d = tick ? '0 : cnt_q + 1'b1;
                if (hit) begin
                    state_d = LOSS;
                end else begin
                    if (tick) en_d = '1;
                    if (goal) begin
                        state_d = WIN;
                        // Direction flips only when the level actually advances.
                        if (level != 2'd3) begin
                            level_d = level + 2'd1;
                            dir_d   = ~lane_dir;
                        end
                    end
                end
            end
            WIN: if (start) begin
                state_d = PLAY;
                cnt_d   = '0;
            end
            LOSS: if (start) begin
                state_d = IDLE;
                level_d = 2'd0;
                dir_d   = DIR_RST;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            lane_enable <= '0;
            lane_dir    <= DIR_RST;
            level       <= 2'd0;
            win         <= 1'b0;
            loss        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lane_enable <= en_d;
            lane_dir    <= dir_d;
            level       <= level_d;
            win         <= (state_d == WIN);
            loss        <= (state_d == LOSS);
        end
    end

`ifdef OBST_SCORE_EN
    always_ff @(posedge clk) begin
        if (reset)
            score <= 8'd0;
        else if (state_q == PLAY && state_d == WIN && score != 8'hff)
            score <= score + 8'd1;
    end
`endif

endmodule

// File: tb/tb_obst_lane_sched.sv
// Randomized scoreboard bench for obst_lane_sched against a game-rule reference model.
module tb_obst_lane_sched;
    localparam int LANES    = 4;
    localparam int TICK_DIV = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  player_row = '0;
    logic [3:0]  player_col = '0;
    logic [63:0] lane_bits = '0;
    logic [3:0]  lane_enable, lane_dir;
    logic        win, loss;
    logic [1:0]  level, state;
`ifdef OBST_SCORE_EN
    logic [7:0]  score;
`endif

    obst_lane_sched #(.LANES(LANES), .TICK_DIV(TICK_DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .player_row (player_row),
        .player_col (player_col),
        .lane_bits  (lane_bits),
        .lane_enable(lane_enable),
        .lane_dir   (lane_dir),
        .win        (win),
        .loss       (loss),
        .level      (level),
`ifdef OBST_SCORE_EN
        .score      (score),
`endif
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] en;
        logic [3:0] dir;
        logic       win;
        logic       loss;
        logic [1:0] level;
        logic [1:0] state;
        logic [7:0] score;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: game mode, level, cycles spent in the current PLAY round, wins.
    int m_state = 0;
    int m_level = 0;
    int m_k     = 0;
    int m_score = 0;

    task automatic step(input logic rst, input logic st, input logic [2:0] row,
                        input logic [3:0] col, input logic [63:0] bits);
        obs_t e;
        int   p, r, c;
        bit   h, g;
        @(negedge clk);
        reset      = rst;
        start      = st;
        player_row = row;
        player_col = col;
        lane_bits  = bits;
        r = int'(row);
        c = int'(col);
        e = '0;
        if (rst) begin
            m_state = 0; m_level = 0; m_k = 0; m_score = 0;
        end else begin
            case (m_state)
                0: if (st) begin m_state = 1; m_k = 0; end
                1: begin
                    p = TICK_DIV >> m_level;
                    if (p < 1) p = 1;
                    h = (r >= 1 && r <= LANES) ? bits[16*(r-1) + c] : 1'b0;
                    g = (r == LANES + 1);
                    if (((m_k + 1) % p == 0) && !h) e.en = 4'b1111;
                    m_k++;
                    if (h) m_state = 3;
                    else if (g) begin
                        m_state = 2;
                        if (m_level < 3) m_level++;
                        if (m_score < 255) m_score++;
                    end
                end
                2: if (st) begin m_state = 1; m_k = 0; end
                default: if (st) begin m_state = 0; m_level = 0; end
            endcase
        end
        e.state = 2'(m_state);
        e.level = 2'(m_level);
        e.win   = (m_state == 2);
        e.loss  = (m_state == 3);
        e.dir   = (m_level % 2 == 1) ? 4'b0101 : 4'b1010;
`ifdef OBST_SCORE_EN
        e.score = 8'(m_score);
`else
        e.score = 8'd0;
`endif
        exp_q.push_back(e);
    endtask

    task automatic safe(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 4'd0, 64'd0);
    endtask

    // Monitor: every output is registered, so one expected snapshot per clock.
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.en = lane_enable; a.dir = lane_dir; a.win = win; a.loss = loss;
                a.level = level; a.state = state;
`ifdef OBST_SCORE_EN
                a.score = score;
`else
                a.score = 8'd0;
`endif
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t got en=%b dir=%b win=%b loss=%b lvl=%0d st=%0d sc=%0d want en=%b dir=%b win=%b loss=%b lvl=%0d st=%0d sc=%0d",
                             $time, a.en, a.dir, a.win, a.loss, a.level, a.state, a.score,
                             e.en, e.dir, e.win, e.loss, e.level, e.state, e.score);
                end
            end
        end
    end

    initial begin
        logic [63:0] bits;
        logic [2:0]  row;
        int          rr;
        int          wait_cyc;
        logic [7:0]  sc_rst;

        repeat (3) step(1'b1, 1'b0, 3'd0, 4'd0, 64'd0);

        @(posedge clk);
        #3;
`ifdef OBST_SCORE_EN
        sc_rst = score;
`else
        sc_rst = 8'd0;
`endif
        n_checks++;
        if (state !== 2'd0 || level !== 2'd0 || lane_enable !== 4'b0000 || win !== 1'b0 ||
            loss !== 1'b0 || lane_dir !== 4'b1010 || sc_rst !== 8'd0) begin
            n_fail++;
            $display("FAIL reset state t=%0t st=%0d lvl=%0d en=%b win=%b loss=%b dir=%b sc=%0d",
                     $time, state, level, lane_enable, win, loss, lane_dir, sc_rst);
        end

        // Start and watch level-0 pulses.
        step(1'b0, 1'b1, 3'd0, 4'd0, 64'd0);
        safe(20);

        // Collision on lane 1 bit 5, then restart to IDLE.
        bits = 64'd1 << (16 + 5);
        step(1'b0, 1'b0, 3'd2, 4'd5, bits);
        safe(10);
        step(1'b0, 1'b1, 3'd0, 4'd0, 64'd0);
        safe(2);

        // Collision landing exactly on a tick.
        step(1'b0, 1'b1, 3'd0, 4'd0, 64'd0);
        safe(7);
        bits = 64'd1 << (48 + 15);
        step(1'b0, 1'b0, 3'd4, 4'd15, bits);
        safe(3);
        step(1'b0, 1'b1, 3'd0, 4'd0, 64'd0);

        // Four consecutive wins to saturate level, then lose and return to IDLE.
        step(1'b0, 1'b1, 3'd0, 4'd0, 64'd0);
        for (int w = 0; w < 4; w++) begin
            safe(6);
            step(1'b0, 1'b0, 3'd5, 4'd0, 64'd0);
            safe(2);
            step(1'b0, 1'b1, 3'd0, 4'd0, 64'd0);
        end
        safe(6);
        step(1'b0, 1'b0, 3'd1, 4'd0, 64'd1);
        step(1'b0, 1'b1, 3'd0, 4'd0, 64'd0);
        safe(3);

        // Reset while a tick and a goal are both due.
        step(1'b0, 1'b1, 3'd0, 4'd0, 64'd0);
        safe(7);
        step(1'b1, 1'b0, 3'd5, 4'd0, 64'd0);
        safe(3);

        // Random play, including out-of-range rows and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            rr = $urandom_range(0, 15);
            if (rr < 8)       row = 3'd0;
            else if (rr < 10) row = 3'd5;
            else if (rr < 12) row = 3'($urandom_range(6, 7));
            else              row = 3'($urandom_range(1, 4));
            bits = {$urandom, $urandom} & {$urandom, $urandom};
            step(($urandom % 300) == 0, ($urandom % 4) == 0, row,
                 4'($urandom_range(0, 15)), bits);
        end

        safe(2);
        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 50) begin
            @(posedge clk);
            wait_cyc++;
        end
        @(negedge clk);
        n_checks++;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL wait expired t=%0t: %0d expected snapshots never observed",
                     $time, exp_q.size());
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
